// File: rtl/cga_pkg.sv
// Shared constants, control codes, state encoding and cell addressing for the
// CGA text buffer writer.
package cga_pkg;

    localparam int COLS         = 80;
    localparam int ROWS         = 25;
    localparam int ROW_BYTES    = 160;
    localparam int SCREEN_BYTES = 4000;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;

    localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);
    localparam logic [12:0] LAST_ADDR   = 13'(SCREEN_BYTES - 1);
    localparam logic [12:0] ROW_STEP    = 13'(ROW_BYTES);
    localparam logic [12:0] FILL_BASE   = 13'(SCREEN_BYTES - ROW_BYTES);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WR_CHAR,
        ST_WR_ATTR,
        ST_SC_RD,
        ST_SC_WAIT,
        ST_SC_WR,
        ST_SC_FILL
    } cga_state_t;

    // Byte address of the character of cell (x,y): (y*80 + x) * 2, built from shifts.
    function automatic logic [12:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
        logic [12:0] yw;
        logic [12:0] xw;
        yw = {8'd0, y};
        xw = {6'd0, x};
        return ((yw << 6) + (yw << 4) + xw) << 1;
    endfunction

    // Everything except the five interpreted control codes is drawn as a glyph.
    function automatic logic is_printable(input logic [7:0] d);
        return !(d == CH_NUL || d == CH_BS || d == CH_LF || d == CH_FF || d == CH_CR);
    endfunction

endpackage

// File: rtl/cga_tty_writer.sv
// TTY front end for the CGA text memory: consumes a byte stream, moves the
// cursor, writes char/attr pairs, and runs the clear and scroll-up sequences
// through memory port B.
//
// Input handshake: a byte is taken on a clock edge where in_valid and in_ready
// are both high; in_ready is only ever high in IDLE, and in_valid is ignored
// otherwise. in_data/in_attr are captured at that edge and need not be held.
module cga_tty_writer
    import cga_pkg::*;
#(
    parameter logic [7:0] DEFAULT_ATTR = 8'h07,
    parameter int          RD_LATENCY   = 1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_attr,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy,
    output logic [12:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output cga_state_t  dbg_state
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    cga_state_t  state;
    logic [12:0] src;
    logic [1:0]  wait_cnt;
    logic [7:0]  attr_q;
    logic [12:0] clear_next;

    assign dbg_state = state;

    // The first CLEAR cycle has mem_we low, so the sweep always restarts at address 0.
    assign clear_next = mem_we ? (mem_address + 13'd1) : 13'd0;

    // Main sequencer: every output is registered and changes together with the state.
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= ST_CLEAR;
            cursor_x    <= 7'd0;
            cursor_y    <= 5'd0;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            mem_we      <= 1'b0;
            mem_address <= 13'd0;
            mem_wdata   <= BLANK_CHAR;
            src         <= ROW_STEP;
            wait_cnt    <= 2'd0;
            attr_q      <= DEFAULT_ATTR;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (mem_we && mem_address == LAST_ADDR) begin
                        mem_we   <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        cursor_x <= 7'd0;
                        cursor_y <= 5'd0;
                        state    <= ST_IDLE;
                    end else begin
                        mem_we      <= 1'b1;
                        mem_address <= clear_next;
                        mem_wdata   <= clear_next[0] ? DEFAULT_ATTR : BLANK_CHAR;
                    end
                end

                ST_IDLE: begin
                    mem_we <= 1'b0;
                    if (!in_ready) begin
                        // One-cycle bubble after a control code.
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_printable(in_data)) begin
                            mem_we      <= 1'b1;
                            mem_address <= cell_addr(cursor_x, cursor_y);
                            mem_wdata   <= in_data;
                            attr_q      <= in_attr;
                            state       <= ST_WR_CHAR;
                        end else begin
                            case (in_data)
                                CH_BS: begin
                                    if (cursor_x != 7'd0) cursor_x <= cursor_x - 7'd1;
                                end
                                CH_CR: cursor_x <= 7'd0;
                                CH_LF: begin
                                    cursor_x <= 7'd0;
                                    if (cursor_y == LAST_ROW) begin
                                        busy        <= 1'b1;
                                        src         <= ROW_STEP;
                                        mem_address <= ROW_STEP;
                                        state       <= ST_SC_RD;
                                    end else begin
                                        cursor_y <= cursor_y + 5'd1;
                                    end
                                end
                                CH_FF: begin
                                    cursor_x <= 7'd0;
                                    cursor_y <= 5'd0;
                                    busy     <= 1'b1;
                                    state    <= ST_CLEAR;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                ST_WR_CHAR: begin
                    mem_address <= mem_address + 13'd1;
                    mem_wdata   <= attr_q;
                    state       <= ST_WR_ATTR;
                end

                ST_WR_ATTR: begin
                    mem_we <= 1'b0;
                    if (cursor_x == LAST_COL) begin
                        cursor_x <= 7'd0;
                        if (cursor_y == LAST_ROW) begin
                            busy        <= 1'b1;
                            src         <= ROW_STEP;
                            mem_address <= ROW_STEP;
                            state       <= ST_SC_RD;
                        end else begin
                            cursor_y <= cursor_y + 5'd1;
                            in_ready <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end else begin
                        cursor_x <= cursor_x + 7'd1;
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end

                ST_SC_RD: begin
                    wait_cnt <= 2'd0;
                    state    <= ST_SC_WAIT;
                end

                // The last wait cycle is the one where mem_rdata is valid; it is
                // captured straight into mem_wdata for the following write.
                ST_SC_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        mem_we      <= 1'b1;
                        mem_address <= src - ROW_STEP;
                        mem_wdata   <= mem_rdata;
                        state       <= ST_SC_WR;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end

                ST_SC_WR: begin
                    if (src == LAST_ADDR) begin
                        mem_address <= FILL_BASE;
                        mem_wdata   <= BLANK_CHAR;
                        state       <= ST_SC_FILL;
                    end else begin
                        mem_we      <= 1'b0;
                        src         <= src + 13'd1;
                        mem_address <= src + 13'd1;
                        state       <= ST_SC_RD;
                    end
                end

                ST_SC_FILL: begin
                    if (mem_address == LAST_ADDR) begin
                        mem_we   <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        cursor_x <= 7'd0;
                        cursor_y <= LAST_ROW;
                        state    <= ST_IDLE;
                    end else begin
                        mem_address <= mem_address + 13'd1;
                        mem_wdata   <= mem_address[0] ? BLANK_CHAR : DEFAULT_ATTR;
                    end
                end

                default: begin
                    mem_we   <= 1'b0;
                    busy     <= 1'b1;
                    in_ready <= 1'b0;
                    state    <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cga_tty_writer.sv
// Directed bench for cga_tty_writer with a byte-wide memory model behind port B.
module tb_cga_tty_writer;

    localparam logic [7:0] ATTR = 8'h07;
    localparam int         LAT  = 1;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic [7:0]  in_attr  = 8'h00;
    logic        in_ready;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;
    logic [12:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    cga_pkg::cga_state_t dbg_state;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem     [0:8191];
    logic [7:0]  rd_pipe [0:LAT-1];
    logic [7:0]  exp_scr [0:3999];
    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];
    int          tx = 0;
    int          ty = 0;

    cga_tty_writer #(.DEFAULT_ATTR(ATTR), .RD_LATENCY(LAT)) dut (
        .clock(clock), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_attr(in_attr),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model: synchronous write, read data delayed LAT clocks
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        for (int i = 0; i < LAT; i++) rd_pipe[i] = 8'h00;
        for (int i = 0; i < 4000; i++) exp_scr[i] = 8'h00;
    end

    always @(posedge clock) begin
        if (mem_we === 1'b1) mem[mem_address] <= mem_wdata;
        rd_pipe[0] <= mem[mem_address];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Write monitor
    always @(negedge clock) begin
        if (mem_we === 1'b1) obs_q.push_back({mem_address, mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard helpers
    task automatic push_write(input int a, input logic [7:0] d);
        exp_q.push_back({13'(a), d});
        exp_scr[a] = d;
    endtask

    task automatic expect_clear();
        for (int a = 0; a < 4000; a++) push_write(a, (a % 2 == 1) ? ATTR : 8'h20);
    endtask

    task automatic compare_writes(input string tag);
        int bad;
        int n;
        bad = 0;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) bad++;
        check({tag, "_seq_bad"}, bad, 0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_screen(input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < 4000; a++) if (mem[a] !== exp_scr[a]) bad++;
        check(tag, bad, 0);
    endtask

    // Driver tasks
    task automatic send(input logic [7:0] d, input logic [7:0] a);
        int n;
        n = 0;
        @(negedge clock);
        while (in_ready !== 1'b1 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (in_ready !== 1'b1) check("send_ready_timeout", 0, 1);
        in_data  = d;
        in_attr  = a;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hEE;
        in_attr  = 8'hEE;
    endtask

    task automatic wait_idle(output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        forever begin
            @(negedge clock);
            if (busy === 1'b1) busy_cycles++;
            if (in_ready === 1'b1) break;
            n++;
            if (n > 20000) begin
                check("idle_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic put_char(input logic [7:0] ch, input logic [7:0] at);
        int a;
        a = (ty * 80 + tx) * 2;
        push_write(a, ch);
        push_write(a + 1, at);
        send(ch, at);
        tx++;
        if (tx == 80) begin
            tx = 0;
            ty++;
        end
    endtask

    task automatic send_lf();
        send(8'h0A, 8'h00);
        tx = 0;
        ty++;
    endtask

    initial begin
        int bc;
        int low;

        // Reset state and the power-up clear
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_cursor", {cursor_y, cursor_x}, 0);
        obs_q.delete();
        expect_clear();
        rst = 1'b0;
        wait_idle(bc);
        compare_writes("clear0");
        check("clear0_cursor", {cursor_y, cursor_x}, 0);
        check("clear0_in_ready", in_ready, 1);

        // 'A' with attribute 1F at (0,0); attribute changes right after transfer
        put_char(8'h41, 8'h1F);
        low = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (in_ready === 1'b1) break;
            low++;
        end
        check("char_ready_low", low, 2);
        compare_writes("char_a");
        check("char_mem0", mem[0], 8'h41);
        check("char_mem1", mem[1], 8'h1F);
        check("char_cursor_x", cursor_x, 1);
        check("char_cursor_y", cursor_y, 0);

        // CR back to column 0, then a full row wraps to (0,1)
        send(8'h0D, 8'h00);
        tx = 0;
        wait_idle(bc);
        check("cr_x1", cursor_x, 0);
        for (int i = 0; i < 80; i++) put_char(8'h21 + 8'(i), 8'h1F);
        wait_idle(bc);
        compare_writes("row0");
        check("row0_mem158", mem[158], 8'h21 + 8'd79);
        check("row0_mem159", mem[159], 8'h1F);
        check("row0_cursor", {cursor_y, cursor_x}, {5'd1, 7'd0});

        // FF mid-screen reruns the full clear and homes the cursor
        for (int i = 0; i < 11; i++) send_lf();
        for (int i = 0; i < 10; i++) put_char(8'h46, 8'h3C);
        wait_idle(bc);
        compare_writes("mid_chars");
        check("mid_cursor", {cursor_y, cursor_x}, {5'd12, 7'd10});
        send(8'h0C, 8'h00);
        tx = 0;
        ty = 0;
        expect_clear();
        wait_idle(bc);
        compare_writes("ff_clear");
        check("ff_cursor", {cursor_y, cursor_x}, 0);
        compare_screen("ff_screen");

        // Row 1 full of 'B', then down to row 24 and partial row of 'C'
        send_lf();
        for (int i = 0; i < 80; i++) put_char(8'h42, 8'h2E);
        for (int i = 0; i < 22; i++) send_lf();
        for (int i = 0; i < 37; i++) put_char(8'h43, 8'h4F);
        wait_idle(bc);
        compare_writes("fill_rows");
        check("pre_cursor", {cursor_y, cursor_x}, {5'd24, 7'd37});

        // BS at x=37, CR, BS at x=0: cursor only, no memory writes
        send(8'h08, 8'h00);
        wait_idle(bc);
        check("bs_x37", cursor_x, 36);
        send(8'h0D, 8'h00);
        wait_idle(bc);
        check("cr_x36", cursor_x, 0);
        send(8'h08, 8'h00);
        wait_idle(bc);
        check("bs_x0", {cursor_y, cursor_x}, {5'd24, 7'd0});
        send(8'h00, 8'h00);
        wait_idle(bc);
        check("nul_cursor", {cursor_y, cursor_x}, {5'd24, 7'd0});
        check("ctrl_no_write", obs_q.size(), 0);

        // LF on the last row scrolls the screen up one row
        send(8'h0A, 8'h00);
        wait_idle(bc);
        check("scroll_busy_cycles", bc, 3 * 3840 + 160);
        check("scroll_writes", obs_q.size(), 4000);
        obs_q.delete();
        for (int a = 0; a < 3840; a++) exp_scr[a] = exp_scr[a + 160];
        for (int a = 3840; a < 4000; a++) exp_scr[a] = (a % 2 == 1) ? ATTR : 8'h20;
        compare_screen("scroll_screen");
        check("scroll_mem0", mem[0], 8'h42);
        check("scroll_mem1", mem[1], 8'h2E);
        check("scroll_row23", mem[3680], 8'h43);
        check("scroll_fill_c", mem[3840], 8'h20);
        check("scroll_fill_a", mem[3999], ATTR);
        check("scroll_cursor", {cursor_y, cursor_x}, {5'd24, 7'd0});

        // Reset in the middle of a second scroll
        send(8'h0A, 8'h00);
        repeat (100) @(negedge clock);
        check("mid_scroll_busy", busy, 1);
        rst = 1'b1;
        @(negedge clock);
        check("abort_mem_we", mem_we, 0);
        check("abort_busy", busy, 1);
        check("abort_cursor", {cursor_y, cursor_x}, 0);
        obs_q.delete();
        exp_q.delete();
        expect_clear();
        rst = 1'b0;
        wait_idle(bc);
        compare_writes("abort_clear");
        check("abort_final_cursor", {cursor_y, cursor_x}, 0);
        compare_screen("abort_screen");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
